// File: rtl/mips_byte_core.sv
// Single-cycle 8-bit MIPS-subset core: add/sub/and/or/slt, addi, lb, sb, beq, j.
// Fetch and data ports share one external memory; PC and register file update on rising clk.
module mips_byte_core #(
    parameter int               WIDTH    = 8,
    parameter int               REGBITS  = 5,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] i_addr,
    input  logic [31:0]      i,
    output logic [WIDTH-1:0] rw_addr,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] w,
    output logic             w_en
);
    localparam int NREGS = 1 << REGBITS;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_ADDI  = 6'b001000,
        OP_LB    = 6'b100000,
        OP_SB    = 6'b101000
    } opcode_e;

    typedef enum logic [5:0] {
        F_ADD = 6'b100000,
        F_SUB = 6'b100010,
        F_AND = 6'b100100,
        F_OR  = 6'b100101,
        F_SLT = 6'b101010
    } funct_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    typedef struct packed {
        logic [5:0]         op;
        logic [REGBITS-1:0] rs;
        logic [REGBITS-1:0] rt;
        logic [REGBITS-1:0] rd;
        logic [5:0]         funct;
        logic [15:0]        imm;
    } instr_t;

    typedef struct packed {
        logic    reg_we;
        logic    dst_rd;
        logic    use_imm;
        logic    from_mem;
        logic    store;
        logic    branch;
        logic    jump;
        alu_op_e alu_op;
    } ctl_t;

    instr_t             ins;
    ctl_t               ctl;
    logic [WIDTH-1:0]   pc;
    logic [WIDTH-1:0]   regs [NREGS];
    logic [WIDTH-1:0]   rs_val, rt_val, imm_val, alu_b, alu_y, wb_val;
    logic [WIDTH-1:0]   pc_plus4, pc_next;
    logic [REGBITS-1:0] wr_idx;
    logic               unused_bits;

    always_comb begin
        ins.op    = i[31:26];
        ins.rs    = i[25:21];
        ins.rt    = i[20:16];
        ins.rd    = i[15:11];
        ins.funct = i[5:0];
        ins.imm   = i[15:0];
    end

    // Immediates are sign-extended then truncated, which is just the low byte.
    assign unused_bits = ^ins.imm[15:WIDTH];

    always_comb begin
        ctl        = '0;
        ctl.alu_op = ALU_ADD;
        case (ins.op)
            OP_RTYPE: begin
                ctl.reg_we = 1'b1;
                ctl.dst_rd = 1'b1;
                case (ins.funct)
                    F_ADD:   ctl.alu_op = ALU_ADD;
                    F_SUB:   ctl.alu_op = ALU_SUB;
                    F_AND:   ctl.alu_op = ALU_AND;
                    F_OR:    ctl.alu_op = ALU_OR;
                    F_SLT:   ctl.alu_op = ALU_SLT;
                    default: ctl.reg_we = 1'b0;
                endcase
            end
            OP_ADDI: begin
                ctl.reg_we  = 1'b1;
                ctl.use_imm = 1'b1;
            end
            OP_LB: begin
                ctl.reg_we   = 1'b1;
                ctl.use_imm  = 1'b1;
                ctl.from_mem = 1'b1;
            end
            OP_SB: begin
                ctl.use_imm = 1'b1;
                ctl.store   = 1'b1;
            end
            OP_BEQ:  ctl.branch = 1'b1;
            OP_J:    ctl.jump   = 1'b1;
            default: ;
        endcase
    end

    // $0 is never written, but guard the read so it is 0 even before reset.
    assign rs_val  = (ins.rs == '0) ? '0 : regs[ins.rs];
    assign rt_val  = (ins.rt == '0) ? '0 : regs[ins.rt];
    assign imm_val = ins.imm[WIDTH-1:0];
    assign alu_b   = ctl.use_imm ? imm_val : rt_val;

    always_comb begin
        case (ctl.alu_op)
            ALU_ADD: alu_y = rs_val + alu_b;
            ALU_SUB: alu_y = rs_val - alu_b;
            ALU_AND: alu_y = rs_val & alu_b;
            ALU_OR:  alu_y = rs_val | alu_b;
            ALU_SLT: alu_y = {{(WIDTH-1){1'b0}}, ($signed(rs_val) < $signed(alu_b))};
            default: alu_y = rs_val + alu_b;
        endcase
    end

    assign pc_plus4 = pc + WIDTH'(4);

    always_comb begin
        pc_next = pc_plus4;
        if (ctl.jump)
            pc_next = {i[WIDTH-3:0], 2'b00};
        else if (ctl.branch && (rs_val == rt_val))
            pc_next = pc_plus4 + {imm_val[WIDTH-3:0], 2'b00};
    end

    assign wr_idx = ctl.dst_rd ? ins.rd : ins.rt;
    assign wb_val = ctl.from_mem ? r : alu_y;

    assign i_addr  = pc;
    assign rw_addr = alu_y;
    assign w       = rt_val;
    assign w_en    = ctl.store & ~rst;

    // Reset has priority, so an instruction in flight when rst rises never commits.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            for (int k = 0; k < NREGS; k++)
                regs[k] <= '0;
        end else begin
            pc <= pc_next;
            if (ctl.reg_we && (wr_idx != '0))
                regs[wr_idx] <= wb_val;
        end
    end

endmodule

// File: tb/tb_mips_byte_core.sv
// Directed bench for mips_byte_core: byte memory model, store scoreboard, fetch-address checks.
module tb_mips_byte_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_addr, rw_addr, r, w;
    logic [31:0] i;
    logic        w_en;

    logic [7:0]  mem [0:255];

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } store_t;

    store_t sb_q[$];
    int     total = 0;
    int     bad   = 0;

    localparam logic [5:0] OP_J = 6'b000010, OP_BEQ = 6'b000100, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LB = 6'b100000, OP_SB = 6'b101000;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010;

    mips_byte_core #(.WIDTH(8), .REGBITS(5), .RESET_PC(8'd0)) dut (
        .clk(clk), .rst(rst), .i_addr(i_addr), .i(i),
        .rw_addr(rw_addr), .r(r), .w(w), .w_en(w_en)
    );

    always #5 clk = ~clk;

    assign i = {mem[i_addr], mem[i_addr + 8'd1], mem[i_addr + 8'd2], mem[i_addr + 8'd3]};
    assign r = mem[rw_addr];

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] tgt);
        return {OP_J, tgt};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    endtask

    task automatic put(input logic [7:0] a, input logic [31:0] word);
        mem[a]         = word[31:24];
        mem[a + 8'd1]  = word[23:16];
        mem[a + 8'd2]  = word[15:8];
        mem[a + 8'd3]  = word[7:0];
    endtask

    task automatic expect_store(input logic [7:0] a, input logic [7:0] d);
        sb_q.push_back('{addr: a, data: d});
    endtask

    // Every observed store must match the head of the scoreboard; otherwise w_en must be low.
    task automatic sample();
        store_t e;
        if (w_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_store", 32'(w_en), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("store_addr", 32'(rw_addr), 32'(e.addr));
                check("store_data", 32'(w), 32'(e.data));
            end
            mem[rw_addr] = w;
        end else begin
            check("w_en_idle", 32'(w_en), 32'd0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic step();
        tick();
        sample();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        check("rst_pc_a", 32'(i_addr), 32'd0);
        step();
        check("rst_pc_b", 32'(i_addr), 32'd0);
        rst = 1'b0;
        #1;
        sample();
    endtask

    logic [7:0] exp_pc [7];

    initial begin
        // addi/sb to 255 and fetch sequencing after reset
        clear_mem();
        put(8'd0, enc_i(OP_ADDI, 5'd0, 5'd2, 16'd5));
        put(8'd4, enc_i(OP_SB, 5'd0, 5'd2, 16'h00FF));
        expect_store(8'd255, 8'd5);
        do_reset();
        check("p1_pc0", 32'(i_addr), 32'd0);
        step();
        check("p1_pc4", 32'(i_addr), 32'd4);
        step();
        check("p1_pc8", 32'(i_addr), 32'd8);
        step();
        check("p1_pc12", 32'(i_addr), 32'd12);
        check("p1_queue", 32'(sb_q.size()), 32'd0);

        // lb then addi wrapping to 0x81; base+offset address wrap
        rst = 1'b1;
        clear_mem();
        mem[64] = 8'h7F;
        put(8'd0,  enc_i(OP_LB,   5'd0, 5'd3, 16'd64));
        put(8'd4,  enc_i(OP_ADDI, 5'd3, 5'd4, 16'd2));
        put(8'd8,  enc_i(OP_SB,   5'd0, 5'd4, 16'd100));
        put(8'd12, enc_i(OP_ADDI, 5'd0, 5'd5, 16'd200));
        put(8'd16, enc_i(OP_LB,   5'd5, 5'd6, 16'd120));
        put(8'd20, enc_i(OP_SB,   5'd0, 5'd6, 16'd101));
        expect_store(8'd100, 8'h81);
        expect_store(8'd101, 8'h7F);
        do_reset();
        for (int n = 0; n < 6; n++) step();
        check("p2_queue", 32'(sb_q.size()), 32'd0);

        // R-type ops, signed slt, unknown funct is a no-op
        rst = 1'b1;
        clear_mem();
        put(8'd0,  enc_i(OP_ADDI, 5'd0, 5'd5, 16'hFFFF));
        put(8'd4,  enc_i(OP_ADDI, 5'd0, 5'd6, 16'd1));
        put(8'd8,  enc_r(5'd7, 5'd5, 5'd6, FN_SLT));
        put(8'd12, enc_i(OP_SB, 5'd0, 5'd7, 16'd200));
        put(8'd16, enc_r(5'd8, 5'd6, 5'd5, FN_SLT));
        put(8'd20, enc_i(OP_SB, 5'd0, 5'd8, 16'd201));
        put(8'd24, enc_r(5'd9, 5'd5, 5'd6, FN_ADD));
        put(8'd28, enc_i(OP_SB, 5'd0, 5'd9, 16'd202));
        put(8'd32, enc_r(5'd10, 5'd6, 5'd5, FN_SUB));
        put(8'd36, enc_i(OP_SB, 5'd0, 5'd10, 16'd203));
        put(8'd40, enc_r(5'd11, 5'd5, 5'd6, FN_AND));
        put(8'd44, enc_i(OP_SB, 5'd0, 5'd11, 16'd204));
        put(8'd48, enc_r(5'd12, 5'd5, 5'd0, FN_OR));
        put(8'd52, enc_i(OP_SB, 5'd0, 5'd12, 16'd205));
        put(8'd56, enc_i(OP_ADDI, 5'd0, 5'd13, 16'h007F));
        put(8'd60, enc_i(OP_ADDI, 5'd0, 5'd14, 16'hFF80));
        put(8'd64, enc_r(5'd15, 5'd14, 5'd13, FN_SLT));
        put(8'd68, enc_i(OP_SB, 5'd0, 5'd15, 16'd206));
        put(8'd72, enc_r(5'd7, 5'd5, 5'd6, 6'b000000));
        put(8'd76, enc_i(OP_SB, 5'd0, 5'd7, 16'd207));
        expect_store(8'd200, 8'd1);
        expect_store(8'd201, 8'd0);
        expect_store(8'd202, 8'd0);
        expect_store(8'd203, 8'd2);
        expect_store(8'd204, 8'd1);
        expect_store(8'd205, 8'hFF);
        expect_store(8'd206, 8'd1);
        expect_store(8'd207, 8'd1);
        do_reset();
        for (int n = 0; n < 20; n++) step();
        check("p3_queue", 32'(sb_q.size()), 32'd0);

        // beq taken/not taken, j, backward branch
        rst = 1'b1;
        clear_mem();
        put(8'd0,  enc_i(OP_BEQ,  5'd0, 5'd0, 16'd1));
        put(8'd4,  enc_i(OP_ADDI, 5'd0, 5'd1, 16'h0055));
        put(8'd8,  enc_i(OP_ADDI, 5'd0, 5'd2, 16'd3));
        put(8'd12, enc_i(OP_BEQ,  5'd2, 5'd0, 16'd1));
        put(8'd16, enc_i(OP_SB,   5'd0, 5'd1, 16'd230));
        put(8'd20, enc_j(26'h10));
        put(8'd64, enc_i(OP_SB,   5'd0, 5'd2, 16'd231));
        put(8'd68, enc_i(OP_BEQ,  5'd0, 5'd0, 16'hFFFE));
        expect_store(8'd230, 8'd0);
        expect_store(8'd231, 8'd3);
        expect_store(8'd231, 8'd3);
        exp_pc = '{8'd8, 8'd12, 8'd16, 8'd20, 8'd64, 8'd68, 8'd64};
        do_reset();
        for (int n = 0; n < 7; n++) begin
            step();
            check($sformatf("p4_pc%0d", n), 32'(i_addr), 32'(exp_pc[n]));
        end
        check("p4_queue", 32'(sb_q.size()), 32'd0);

        // $0 writes discarded; reset during sb aborts the store and clears registers
        rst = 1'b1;
        clear_mem();
        put(8'd0,  enc_i(OP_ADDI, 5'd0, 5'd1, 16'd7));
        put(8'd4,  enc_i(OP_ADDI, 5'd0, 5'd0, 16'd9));
        put(8'd8,  enc_i(OP_SB,   5'd0, 5'd0, 16'd20));
        put(8'd12, enc_i(OP_SB,   5'd0, 5'd1, 16'd21));
        expect_store(8'd20, 8'd0);
        do_reset();
        step();
        step();
        tick();
        check("p5_sb_pc", 32'(i_addr), 32'd12);
        rst = 1'b1;
        #1;
        check("p5_abort_wen", 32'(w_en), 32'd0);
        sample();
        tick();
        check("p5_restart_pc", 32'(i_addr), 32'd0);
        put(8'd0, 32'h0000_0000);
        expect_store(8'd20, 8'd0);
        expect_store(8'd21, 8'd0);
        rst = 1'b0;
        #1;
        sample();
        for (int n = 0; n < 4; n++) step();
        check("p5_queue", 32'(sb_q.size()), 32'd0);

        // jump to top of memory, PC+4 wraps to 0
        rst = 1'b1;
        clear_mem();
        put(8'd0,   enc_j(26'd63));
        put(8'd252, enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1));
        do_reset();
        step();
        check("p6_pc252", 32'(i_addr), 32'd252);
        step();
        check("p6_wrap", 32'(i_addr), 32'd0);
        step();
        check("p6_again", 32'(i_addr), 32'd252);
        check("p6_queue", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
